sub16_serial: RTL and testbench
===============================

Name: sub16_serial

Overview:
Bit-serial 16-bit two's-complement subtractor: out = a - b, one bit per clock, LSB first, with a start/done handshake.
It is the sequential counterpart of the ripple adder/incrementer datapath: it subtracts instead of adding, trading latency for one bit-slice of logic.
It sits beside the ALU path and serves multi-cycle decrement and compare operations (a < b via borrow).

Parameters:
WIDTH, 16, operand/result width in bits; bit-counter width = clog2(WIDTH)+1.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when state is IDLE or DONE
a  input  WIDTH  minuend; captured on the accepting edge
b  input  WIDTH  subtrahend; captured on the accepting edge
busy  output  1  high while state = SHIFT
done  output  1  one-cycle pulse; out/flags valid
out  output  WIDTH  difference a - b mod 2^WIDTH; held until next accepted start
borrow  output  1  final borrow; 1 iff unsigned a < b
zr  output  1  out == 0
ng  output  1  out[WIDTH-1]

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset); no asynchronous paths.
- Reset: state=IDLE; busy=0; done=0; out=0; borrow=0; zr=1 (derived from out=0); ng=0; internal shift registers and counter cleared.
- States:
  - IDLE: start=1 -> latch a,b; borrow-in=0; cnt=0; go to SHIFT.
  - SHIFT: each edge consumes bit cnt of a and b:
    - d = a_i ^ b_i ^ bin
    - bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin)
    - d is shifted into out from the MSB side; bin <= bout; cnt++.
    - After the edge processing bit WIDTH-1, go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back, no bubble); otherwise go to IDLE.
- Latency: start sampled at edge E0. Bit i is written at edge E(i+1). done is high in the cycle following E(WIDTH), so done is seen WIDTH+1 edges after E0 for WIDTH=16.
- out during SHIFT: holds a partial shift value; it is not guaranteed stable until done.
- Flags: borrow, zr and ng update only at the transition into DONE; they hold otherwise.
- start while busy: ignored; operands are not re-captured.
- Reset mid-operation: reset wins over every other input on that edge; the block returns to the full reset state.
- a == b: out=0, borrow=0, zr=1.
- Boundary values: a=0, b=0xFFFF -> out=0x0001, borrow=1.
- Width rule: everything is modulo 2^WIDTH; there are no extension bits.

Optional Feature:
- Macro: SUB16_SERIAL_OVF_EN.
- When defined: adds output ovf (1 bit), signed overflow = (a[MSB] != b[MSB]) & (out[MSB] != a[MSB]). It is computed from the latched operands, updated on entry to DONE, held otherwise, and reset to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package sub16_pkg:
  - state encoding constants S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2
  - default WIDTH=16
  - counter-width constant
- Sub-module full_subtractor (x, y, bin -> d, bout): the combinational one-bit slice, instanced once.
- Top-level sub16_serial holds the FSM, bit counter, operand shift registers and flag registers.

Test Plan:
1. a=0x0005, b=0x0003, start one cycle -> busy for 16 cycles; done pulse at edge 17; out=0x0002, borrow=0, zr=0, ng=0.
2. a=0x0003, b=0x0005 -> out=0xFFFE, borrow=1, ng=1, zr=0.
3. a=0x1234, b=0x1234 -> out=0x0000, zr=1, borrow=0. Then start asserted in the DONE cycle with a=0x0000, b=0xFFFF -> next result out=0x0001, borrow=1, no idle bubble.
4. Start a=0x00FF, b=0x0001; at cycle 5 re-assert start with a=0xAAAA -> ignored; result out=0x00FE.
5. Start a=0x8000, b=0x0001; assert reset at cycle 8 -> next cycle state IDLE, out=0, busy=0, done never pulses. A fresh start with a=0x0010, b=0x0001 -> out=0x000F.
6. With SUB16_SERIAL_OVF_EN:
   - a=0x8000, b=0x0001 -> out=0x7FFF, ovf=1.
   - a=0x7FFF, b=0xFFFF -> out=0x8000, ovf=1.
   - a=0x0005, b=0x0003 -> ovf=0.

Source files
------------

// File: rtl/sub16_pkg.sv
// Shared constants for the bit-serial subtractor.
// Holds the state encoding, the default width and the bit-counter width.
package sub16_pkg;

    // Default operand and result width.
    localparam int DEF_WIDTH = 16;

    // FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // The counter needs one extra bit so it can hold WIDTH itself.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/sub16_serial_full_subtractor.sv
// One-bit full subtractor slice: d = x - y - bin, with bout as the borrow out.
// Ports: x, y, bin (inputs); d, bout (outputs).
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub16_serial.sv
// Bit-serial two's-complement subtractor: out = a - b, LSB first, one bit per clock.
// Ports: clock, reset (sync, active-high), start, a, b -> busy, done, out, borrow, zr, ng.
// Optional macro SUB16_SERIAL_OVF_EN adds output ovf (signed overflow).
module sub16_serial
    import sub16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             zr,
    output logic             ng
`ifdef SUB16_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_w(WIDTH);
    localparam int IW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             accept;
    logic             last;
    logic             xi;
    logic             yi;
    logic             d;
    logic             bout;
    logic [WIDTH-1:0] out_nx;

    // Operands stay put; the counter selects the bit being consumed.
    assign xi = ra[cnt[IW-1:0]];
    assign yi = rb[cnt[IW-1:0]];

    full_subtractor u_fs (
        .x    (xi),
        .y    (yi),
        .bin  (bin),
        .d    (d),
        .bout (bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 is in place.
    assign out_nx = {d, out[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        last     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last     = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // Back-to-back start is taken without an idle bubble.
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_SHIFT;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ra     <= '0;
            rb     <= '0;
            cnt    <= '0;
            bin    <= 1'b0;
            out    <= '0;
            borrow <= 1'b0;
            zr     <= 1'b1;
            ng     <= 1'b0;
        end else if (accept) begin
            ra  <= a;
            rb  <= b;
            cnt <= '0;
            bin <= 1'b0;
        end else if (busy) begin
            out <= out_nx;
            bin <= bout;
            cnt <= cnt + 1'b1;
            // Flags only move on the edge that enters DONE.
            if (last) begin
                borrow <= bout;
                zr     <= (out_nx == '0);
                ng     <= out_nx[WIDTH-1];
            end
        end
    end

`ifdef SUB16_SERIAL_OVF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (busy && last) begin
            ovf <= (ra[WIDTH-1] != rb[WIDTH-1]) &&
                   (out_nx[WIDTH-1] != ra[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_sub16_serial.sv
// Scoreboard bench for sub16_serial: directed plan cases plus random operands.
// Expected results come from plain integer arithmetic on the operands.
module tb_sub16_serial;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        borrow;
    logic        zr;
    logic        ng;
`ifdef SUB16_SERIAL_OVF_EN
    logic        ovf;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] o;
        logic        br;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    exp_t q[$];
    logic prev_done = 1'b0;

    sub16_serial dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .borrow (borrow),
        .zr     (zr),
        .ng     (ng)
`ifdef SUB16_SERIAL_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv);
        exp_t e;
        int   ua = int'(av);
        int   ub = int'(bv);
        int   sa = int'($signed(av));
        int   sb = int'($signed(bv));
        int   sd = sa - sb;
        int   ud = ua - ub;
        e.br = (ua < ub);
        e.o  = 16'((ud + 65536) % 65536);
        e.z  = (e.o == 16'h0);
        e.n  = (e.o >= 16'h8000);
        e.v  = (sd > 32767) || (sd < -32768);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h need %h", name, got, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clock) begin
        if (done) begin
            exp_t e;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done out=%h", out);
            end else begin
                e = q.pop_front();
                if (out !== e.o || borrow !== e.br || zr !== e.z || ng !== e.n
`ifdef SUB16_SERIAL_OVF_EN
                    || ovf !== e.v
`endif
                   ) begin
                    fails++;
                    $display("FAIL result got out=%h br=%b zr=%b ng=%b need out=%h br=%b zr=%b ng=%b v=%b",
                             out, borrow, zr, ng, e.o, e.br, e.z, e.n, e.v);
                end
            end
            tests++;
            if (prev_done || busy) begin
                fails++;
                $display("FAIL done_pulse got prev_done=%b busy=%b need 0 0", prev_done, busy);
            end
        end
        prev_done <= done;
    end

    // Called away from the posedge; returns #1 after the accepting edge.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input bit push);
        start = 1'b1;
        a     = av;
        b     = bv;
        if (push) q.push_back(model(av, bv));
        @(posedge clock);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
    endtask

    // Counts edges from the accepting edge until done is sampled; ends at that negedge.
    task automatic wait_done(input int elapsed);
        int k    = elapsed;
        bit seen = 1'b0;
        while (k < 40 && !seen) begin
            k++;
            @(negedge clock);
            seen = done;
        end
        tests++;
        if (!seen || k != 17) begin
            fails++;
            $display("FAIL latency got %0d seen=%b need 17", k, seen);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_state", {busy, done, out, borrow, zr, ng}, {1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0});

        // Plan 1, with hold check after done.
        issue(16'h0005, 16'h0003, 1);
        chk("busy_shift", 32'(busy), 32'd1);
        wait_done(0);
        repeat (3) @(negedge clock);
        chk("hold_out", {out, borrow, zr, ng}, {16'h0002, 1'b0, 1'b0, 1'b0});

        // Plan 2.
        issue(16'h0003, 16'h0005, 1);
        wait_done(0);
        @(negedge clock);

        // Plan 3: back-to-back start in the DONE cycle.
        issue(16'h1234, 16'h1234, 1);
        wait_done(0);
        issue(16'h0000, 16'hFFFF, 1);
        wait_done(0);
        @(negedge clock);

        // Plan 4: start while busy is ignored.
        issue(16'h00FF, 16'h0001, 1);
        repeat (4) @(negedge clock);
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(4);
        @(negedge clock);

        // Plan 5: reset mid-operation; no result expected.
        issue(16'h8000, 16'h0001, 0);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        chk("mid_rst", {busy, done, out, borrow, zr, ng}, {1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0});
        repeat (20) @(negedge clock);
        chk("no_done_after_rst", 32'(done), 32'd0);
        issue(16'h0010, 16'h0001, 1);
        wait_done(0);
        @(negedge clock);

        // Overflow cases (results also checked in default build).
        issue(16'h8000, 16'h0001, 1);
        wait_done(0);
        @(negedge clock);
        issue(16'h7FFF, 16'hFFFF, 1);
        wait_done(0);
        @(negedge clock);

        // Random operands, some issued back-to-back.
        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = (i % 6 == 0) ? ra : 16'($urandom);
            issue(ra, rb, 1);
            wait_done(0);
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
        end

        repeat (25) @(negedge clock);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
